// File: rtl/sram_bist_pkg.sv
// Shared types and the address-derived test pattern for the SRAM self-test engine.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_W_STROBE, S_W_GAP, S_R_ISSUE, S_R_DRAIN, S_DONE, S_FAIL
    } state_t;

    // bit 0 marks a read phase, bit 1 selects the inverted pattern
    typedef enum logic [1:0] {PH_W0 = 2'b00, PH_R0 = 2'b01, PH_W1 = 2'b10, PH_R1 = 2'b11} phase_t;

    localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

    function automatic logic [15:0] pattern(input logic [15:0] a, input logic [15:0] seed,
                                            input logic inv);
        pattern = (a ^ seed) ^ {16{inv}};
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Request/response side of the SRAM controller port; the BIST is the master.
interface sram_bist_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] ramctl_read_address;
    logic [ADDR_W-1:0] ramctl_write_address;
    logic              ramctl_write;
    logic [DATA_W-1:0] ramctl_data_in;
    logic [DATA_W-1:0] ramctl_data_out;

    modport master (
        output ramctl_read_address, ramctl_write_address, ramctl_write, ramctl_data_in,
        input  ramctl_data_out
    );
    modport slave (
        input  ramctl_read_address, ramctl_write_address, ramctl_write, ramctl_data_in,
        output ramctl_data_out
    );
endinterface

// File: rtl/sram_bist_checker.sv
// Read-back delay line, comparator and first-failure capture.
module sram_bist_checker #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk_100,
    input  logic              sys_reset_n,
    input  logic              clr,
    input  logic              iss_vld,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_exp,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mismatch,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_expected
);
    // iss_* is already the registered issue stage; this is the second stage,
    // lining expected data up with read data that returns two edges after issue
    logic              vld_d1;
    logic [ADDR_W-1:0] addr_d1;
    logic [DATA_W-1:0] exp_d1;
    logic              failed;

    assign mismatch = vld_d1 && (rd_data != exp_d1);

    always_ff @(posedge clk_100 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            vld_d1        <= 1'b0;
            addr_d1       <= '0;
            exp_d1        <= '0;
            failed        <= 1'b0;
            fail_addr     <= '0;
            fail_data     <= '0;
            fail_expected <= '0;
        end else begin
            vld_d1  <= iss_vld;
            addr_d1 <= iss_addr;
            exp_d1  <= iss_exp;
            if (clr) begin
                failed        <= 1'b0;
                fail_addr     <= '0;
                fail_data     <= '0;
                fail_expected <= '0;
            end else if (mismatch && !failed) begin
                // words still in flight behind the first failure must not overwrite it
                failed        <= 1'b1;
                fail_addr     <= addr_d1;
                fail_data     <= rd_data;
                fail_expected <= exp_d1;
            end
        end
    end
endmodule

// File: rtl/sram_bist.sv
// SRAM self-test: W0(P) / R0(P) / W1(~P) / R1(~P) over 0..LAST_ADDR, stops on first mismatch.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int                ADDR_W    = 18,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 18'h3FFFF,
    parameter logic [15:0]       SEED      = DEFAULT_SEED
) (
    input  logic              clk_100,
    input  logic              sys_reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_expected,
    sram_bist_if.master       ram
);
    state_t            state;
    phase_t            phase;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nx;
    logic              drain_cnt;
    logic              start_r, start_rr;
    logic              go, idle_like, clr, mismatch;
    logic              wr_q, iss_vld;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q, iss_exp;

    assign addr_nx   = addr + 1'b1;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);
    // start is registered once before edge detection, so busy rises one edge after sampling
    assign go        = start_r && !start_rr;
    assign clr       = go && idle_like;

    assign ram.ramctl_write         = wr_q;
    assign ram.ramctl_write_address = wr_addr_q;
    assign ram.ramctl_data_in       = wr_data_q;
    assign ram.ramctl_read_address  = rd_addr_q;

    always_ff @(posedge clk_100 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state     <= S_IDLE;
            phase     <= PH_W0;
            addr      <= '0;
            drain_cnt <= 1'b0;
            start_r   <= 1'b0;
            start_rr  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            iss_vld   <= 1'b0;
            iss_exp   <= '0;
        end else begin
            start_r  <= start;
            start_rr <= start_r;
            case (state)
                S_IDLE, S_DONE, S_FAIL: if (go) begin
                    state     <= S_W_STROBE;
                    phase     <= PH_W0;
                    addr      <= '0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    wr_q      <= 1'b1;
                    wr_addr_q <= '0;
                    wr_data_q <= pattern(16'h0000, SEED, 1'b0);
                end
                S_W_STROBE: begin
                    wr_q  <= 1'b0;
                    state <= S_W_GAP;
                end
                S_W_GAP: if (addr == LAST_ADDR) begin
                    phase     <= phase[1] ? PH_R1 : PH_R0;
                    addr      <= '0;
                    state     <= S_R_ISSUE;
                    rd_addr_q <= '0;
                    iss_vld   <= 1'b1;
                    iss_exp   <= pattern(16'h0000, SEED, phase[1]);
                end else begin
                    addr      <= addr_nx;
                    state     <= S_W_STROBE;
                    wr_q      <= 1'b1;
                    wr_addr_q <= addr_nx;
                    wr_data_q <= pattern(addr_nx[15:0], SEED, phase[1]);
                end
                S_R_ISSUE: if (mismatch) begin
                    state   <= S_FAIL;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    iss_vld <= 1'b0;
                end else if (addr == LAST_ADDR) begin
                    iss_vld   <= 1'b0;
                    drain_cnt <= 1'b0;
                    state     <= S_R_DRAIN;
                end else begin
                    addr      <= addr_nx;
                    rd_addr_q <= addr_nx;
                    iss_exp   <= pattern(addr_nx[15:0], SEED, phase[1]);
                end
                S_R_DRAIN: if (mismatch) begin
                    state <= S_FAIL;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (!drain_cnt) begin
                    drain_cnt <= 1'b1;
                end else if (phase == PH_R1) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else begin
                    phase     <= PH_W1;
                    addr      <= '0;
                    state     <= S_W_STROBE;
                    wr_q      <= 1'b1;
                    wr_addr_q <= '0;
                    wr_data_q <= pattern(16'h0000, SEED, 1'b1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sram_bist_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_checker (
        .clk_100       (clk_100),
        .sys_reset_n   (sys_reset_n),
        .clr           (clr),
        .iss_vld       (iss_vld),
        .iss_addr      (rd_addr_q),
        .iss_exp       (iss_exp),
        .rd_data       (ram.ramctl_data_out),
        .mismatch      (mismatch),
        .fail_addr     (fail_addr),
        .fail_data     (fail_data),
        .fail_expected (fail_expected)
    );
endmodule

// File: tb/tb_sram_bist.sv
// Bench: sram_bist + behavioural controller/SRAM (LAST_ADDR=3), scoreboarded run results.
module tb_sram_bist;
    localparam int AW = 18;
    localparam int DW = 16;

    typedef struct packed {
        logic          pass;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] expd;
        logic [31:0]   cycles;
        logic [31:0]   strobes;
    } exp_t;

    logic clk_100 = 1'b0;
    logic sys_reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data, fail_expected;

    sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

    sram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(18'd3), .SEED(16'hA5C3)) dut (
        .clk_100       (clk_100),
        .sys_reset_n   (sys_reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_addr     (fail_addr),
        .fail_data     (fail_data),
        .fail_expected (fail_expected),
        .ram           (ram)
    );

    always #5 clk_100 = ~clk_100;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // controller: request registered on the next edge, read data latched on the falling edge
    logic [DW-1:0] mem [0:3];
    logic [AW-1:0] rq_addr = '0;
    logic stuck0 = 1'b0;
    logic w1_fault = 1'b0;

    always @(posedge clk_100) begin
        rq_addr <= ram.ramctl_read_address;
        if (ram.ramctl_write &&
            !(w1_fault && ram.ramctl_write_address == 18'd3 && ram.ramctl_data_in == 16'h5A3F))
            mem[ram.ramctl_write_address[1:0]] <= ram.ramctl_data_in;
    end

    always @(negedge clk_100)
        ram.ramctl_data_out <= mem[rq_addr[1:0]] & (stuck0 ? 16'hFFFE : 16'hFFFF);

    // monitor: strobe spacing, busy length, and result checking on each done rise
    int busy_cnt = 0;
    int strobes = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0, prev_wr = 1'b0;

    always @(negedge clk_100) begin
        exp_t e;
        if (busy && !prev_busy) begin
            busy_cnt = 0;
            strobes = 0;
        end
        if (busy) busy_cnt++;
        if (ram.ramctl_write) begin
            strobes++;
            check("strobe_gap", 32'(prev_wr), 32'd0);
        end
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pass", 32'(pass), 32'(e.pass));
                check("busy_cycles", 32'(busy_cnt), e.cycles);
                check("strobe_count", 32'(strobes), e.strobes);
                check("fail_addr", 32'(fail_addr), 32'(e.addr));
                check("fail_data", 32'(fail_data), 32'(e.data));
                check("fail_expected", 32'(fail_expected), 32'(e.expd));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
        prev_busy = busy;
        prev_done = done;
        prev_wr   = ram.ramctl_write;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, "_fail_data"}, 32'(fail_data), 32'd0);
        check({tag, "_fail_exp"}, 32'(fail_expected), 32'd0);
        check({tag, "_write"}, 32'(ram.ramctl_write), 32'd0);
        check({tag, "_waddr"}, 32'(ram.ramctl_write_address), 32'd0);
        check({tag, "_raddr"}, 32'(ram.ramctl_read_address), 32'd0);
        check({tag, "_wdata"}, 32'(ram.ramctl_data_in), 32'd0);
    endtask

    task automatic do_start();
        @(posedge clk_100); #1 start = 1'b1;
        repeat (2) @(posedge clk_100);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        int k = 0;
        while (!done && k < lim) begin
            @(negedge clk_100);
            k++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk_100);
    endtask

    task automatic push(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] x, input int cyc, input int stb);
        exp_t e;
        e.pass = p; e.addr = a; e.data = d; e.expd = x;
        e.cycles = 32'(cyc); e.strobes = 32'(stb);
        sb.push_back(e);
    endtask

    initial begin
        int k;
        // reset state
        repeat (3) @(posedge clk_100);
        #1 check_all_zero("reset");
        sys_reset_n = 1'b1;
        repeat (2) @(posedge clk_100);

        // clean run: 6N+4 = 28 busy cycles, 8 strobes, SRAM left holding ~P
        push(1'b1, '0, '0, '0, 28, 8);
        do_start();
        wait_done("clean", 100);
        check("mem0_invP", 32'(mem[0]), 32'h5A3C);
        check("mem2_invP", 32'(mem[2]), 32'h5A3E);

        // bit 0 stuck low: first R0 compare at addr 0 fails, 10 busy cycles
        stuck0 = 1'b1;
        push(1'b0, 18'd0, 16'hA5C2, 16'hA5C3, 10, 4);
        do_start();
        wait_done("stuck", 100);
        stuck0 = 1'b0;

        // addr 3 keeps its W0 value through W1: fails last compare of R1
        w1_fault = 1'b1;
        push(1'b0, 18'd3, 16'hA5C0, 16'h5A3F, 27, 8);
        do_start();
        wait_done("w1fault", 100);
        w1_fault = 1'b0;

        // restart from FAIL clears the failure record
        push(1'b1, '0, '0, '0, 28, 8);
        do_start();
        wait_done("after_fail", 100);

        // reset mid-W1 while a strobe is high
        do_start();
        k = 0;
        while (!(ram.ramctl_write && strobes >= 5) && k < 100) begin
            @(negedge clk_100);
            k++;
        end
        check("midrun_strobe_seen", 32'(ram.ramctl_write), 32'd1);
        #1 sys_reset_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        @(posedge clk_100); #1 sys_reset_n = 1'b1;
        push(1'b1, '0, '0, '0, 28, 8);
        do_start();
        wait_done("after_reset", 100);

        // start pulse while busy is ignored
        push(1'b1, '0, '0, '0, 28, 8);
        do_start();
        repeat (4) @(posedge clk_100);
        #1 start = 1'b1;
        @(posedge clk_100); #1 start = 1'b0;
        wait_done("start_busy", 100);
        repeat (5) @(negedge clk_100);
        check("no_restart_busy", 32'(busy), 32'd0);
        check("no_restart_done", 32'(done), 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end
endmodule
